// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with valid/ready holding register
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   rx           asynchronous serial line, idle high
//   data_out     received word, LSB = first data bit
//   data_valid   holding register full
//   data_ready   consumer accepts the held word
//   parity_err   parity mismatch on the held word, qualified by data_valid
//   frame_error  one-cycle pulse, a stop bit decided low
//   overrun      one-cycle pulse, a completed word was dropped
//   rts          registered flow control, low = ready to receive
//   busy         high while a frame is in progress

module uart_rx_param #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 rts,
  output logic                 busy
);

  localparam int TICKS_PER_SAMPLE = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  if (TICKS_PER_SAMPLE < 1) begin : g_bad_ticks
    $error("uart_rx_param: TICKS_PER_SAMPLE must be at least 1");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_cfg
    $error("uart_rx_param: unsupported frame configuration");
  end

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_DECIDE  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [1:0]           hist_q;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, fe_q, ov_q, rts_q;

  logic start_edge, tick, decide, wrap, bit_val, par_x, commit, fe_set;

  assign start_edge = prev_q & ~sync2_q;
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign decide     = tick && (samp_q == S_DECIDE);
  assign wrap       = tick && (samp_q == S_LAST);
  // hist_q holds samples OVERSAMPLE/2-1 and OVERSAMPLE/2; the third vote is the live sample.
  assign bit_val    = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
  assign par_x      = (^shift_q) ^ bit_val;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    samp_d     = samp_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    commit     = 1'b0;
    fe_set     = 1'b0;
    if (tick) samp_d = wrap ? '0 : samp_q + SW'(1);
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          samp_d     = '0;
          par_bad_d  = 1'b0;
        end
      end
      S_START: begin
        if (decide && bit_val) begin
          state_d = S_IDLE;  // line came back high: glitch, not a start bit
        end else if (wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx_q == DATA_LAST) begin
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) par_bad_d = (PARITY == 1) ? ~par_x : par_x;
        if (wrap) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (decide && !bit_val) begin
          fe_set  = 1'b1;
          state_d = S_BREAK;
        end else if (decide && (bit_idx_q == STOP_LAST)) begin
          // Commit on the decision tick so a following start bit is never missed.
          commit  = 1'b1;
          state_d = S_IDLE;
        end else if (wrap) begin
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      S_BREAK: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b0;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      hist_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      if (tick) hist_q <= {hist_q[0], sync2_q};
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      if (commit && (!valid_q || data_ready)) begin
        data_q  <= shift_q;
        perr_q  <= par_bad_q;
        valid_q <= 1'b1;
      end else if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end
      ov_q  <= commit && valid_q && !data_ready;
      fe_q  <= fe_set;
      rts_q <= valid_q && !data_ready;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_q;
  assign frame_error = fe_q;
  assign overrun     = ov_q;
  assign rts         = rts_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param (8N1, 8E1, 7N2 instances)
module tb_uart_rx_param;

  localparam int CLKF = 1600000;
  localparam int BAUD = 100000;
  localparam int OS   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       rx_r   [3];
  logic       rdy_r  [3];
  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  logic [8:0] dout_w [3];
  logic       val_w [3], perr_w [3], fe_w [3], ov_w [3], rts_w [3], busy_w [3];

  assign dout_w[0] = {1'b0, dout0};
  assign dout_w[1] = {1'b0, dout1};
  assign dout_w[2] = {2'b00, dout2};

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx(rx_r[0]), .data_out(dout0), .data_valid(val_w[0]),
    .data_ready(rdy_r[0]), .parity_err(perr_w[0]), .frame_error(fe_w[0]), .overrun(ov_w[0]),
    .rts(rts_w[0]), .busy(busy_w[0]));

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rx(rx_r[1]), .data_out(dout1), .data_valid(val_w[1]),
    .data_ready(rdy_r[1]), .parity_err(perr_w[1]), .frame_error(fe_w[1]), .overrun(ov_w[1]),
    .rts(rts_w[1]), .busy(busy_w[1]));

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .rx(rx_r[2]), .data_out(dout2), .data_valid(val_w[2]),
    .data_ready(rdy_r[2]), .parity_err(perr_w[2]), .frame_error(fe_w[2]), .overrun(ov_w[2]),
    .rts(rts_w[2]), .busy(busy_w[2]));

  // Frame shape of each instance.
  function automatic int nb_of(input int i);  return (i == 2) ? 7 : 8; endfunction
  function automatic int par_of(input int i); return (i == 1) ? 2 : 0; endfunction
  function automatic int ns_of(input int i);  return (i == 2) ? 2 : 1; endfunction

  // Reference parity rule: count of ones over data plus parity bit.
  function automatic int exp_perr(input int i, input int data, input int pbit);
    int ones;
    if (par_of(i) == 0) return 0;
    ones = $countones(data) + pbit;
    if (par_of(i) == 1) return (ones % 2 == 0) ? 1 : 0;
    return (ones % 2 == 1) ? 1 : 0;
  endfunction

  typedef struct { int inst; int kind; int data; int perr; int cyc; } ev_t;
  ev_t evq[$];

  function automatic ev_t mk_ev(input int i, input int k, input int d, input int p, input int c);
    ev_t e;
    e.inst = i; e.kind = k; e.data = d; e.perr = p; e.cyc = c;
    return e;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output observer: kind 0 = new word delivered, 1 = frame_error pulse, 2 = overrun pulse.
  logic fresh [3] = '{1'b1, 1'b1, 1'b1};
  int   vcnt  [3] = '{0, 0, 0};
  int   bcnt  [3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (val_w[i] && fresh[i]) evq.push_back(mk_ev(i, 0, int'(dout_w[i]), int'(perr_w[i]), cyc));
      if (fe_w[i]) evq.push_back(mk_ev(i, 1, 0, 0, cyc));
      if (ov_w[i]) evq.push_back(mk_ev(i, 2, 0, 0, cyc));
      fresh[i] <= !val_w[i] || rdy_r[i];
      vcnt[i]  <= vcnt[i] + int'(val_w[i]);
      bcnt[i]  <= bcnt[i] + int'(busy_w[i]);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks enter and leave 2 time units after a rising edge.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input int inst, input logic v, input int n);
    rx_r[inst] = v;
    tick_n(n);
  endtask

  task automatic send_frame(input int inst, input int data, input int pbit,
                            input int s1, input int s2, output int t0);
    t0 = cyc;
    drive(inst, 1'b0, OS);
    for (int b = 0; b < nb_of(inst); b++) drive(inst, 1'(data >> b), OS);
    if (pbit >= 0) drive(inst, 1'(pbit), OS);
    drive(inst, 1'(s1), OS);
    if (ns_of(inst) == 2) drive(inst, 1'(s2), OS);
  endtask

  // Sends one frame and checks the single resulting event against the frame rules.
  // The bit-index arithmetic: the decision for bit b lands 3 cycles of input latency
  // plus OS/2+1 samples into that bit, and the flag/word shows one cycle later.
  task automatic run_frame(input int inst, input int data, input int pbit,
                           input int s1, input int s2, input int brk);
    int t0, np, last, badi;
    ev_t e;
    np   = (par_of(inst) != 0) ? 1 : 0;
    last = nb_of(inst) + np + ns_of(inst);
    badi = -1;
    if (s1 == 0) badi = nb_of(inst) + np + 1;
    else if (ns_of(inst) == 2 && s2 == 0) badi = nb_of(inst) + np + 2;
    evq.delete();
    send_frame(inst, data, pbit, s1, s2, t0);
    if (badi >= 0) begin
      drive(inst, 1'b0, brk);
      drive(inst, 1'b1, 6);
    end
    chk("ev_count", evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk("ev_inst", e.inst, inst);
      if (badi >= 0) begin
        chk("fe_kind", e.kind, 1);
        chk("fe_cycle", e.cyc, t0 + 3 + OS * badi + OS / 2 + 2);
      end else begin
        chk("word_kind", e.kind, 0);
        chk("word_data", e.data, data);
        chk("word_perr", e.perr, exp_perr(inst, data, pbit));
        chk("word_cycle", e.cyc, t0 + 3 + OS * last + OS / 2 + 2);
      end
    end
  endtask

  int   t0a, t0b, v0, b0, d, p, s1, s2;
  ev_t  e;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_r[i]  = 1'b1;
      rdy_r[i] = 1'b1;
    end
    @(posedge clk);
    #2;
    tick_n(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_dout", i), dout_w[i], 0);
      chk($sformatf("rst%0d_valid", i), val_w[i], 0);
      chk($sformatf("rst%0d_perr", i), perr_w[i], 0);
      chk($sformatf("rst%0d_fe", i), fe_w[i], 0);
      chk($sformatf("rst%0d_ovr", i), ov_w[i], 0);
      chk($sformatf("rst%0d_rts", i), rts_w[i], 0);
      chk($sformatf("rst%0d_busy", i), busy_w[i], 0);
    end
    reset = 1'b0;
    tick_n(5);

    // 8N1 basic word, valid held exactly one cycle with data_ready high.
    v0 = vcnt[0];
    run_frame(0, 'hA5, -1, 1, 1, 0);
    tick_n(3);
    chk("a5_valid_width", vcnt[0] - v0, 1);

    // Even parity: 0x03 with parity bit 1 is wrong, with 0 is right.
    run_frame(1, 'h03, 1, 1, 1, 0);
    run_frame(1, 'h03, 0, 1, 1, 0);

    // Stop bit low, line held low, then recovery.
    run_frame(0, 'h3C, -1, 0, 0, 40);
    run_frame(0, 'h5A, -1, 1, 1, 0);

    // False start: 4 low cycles.
    evq.delete();
    b0 = bcnt[0];
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    chk("fs_busy_cycles", bcnt[0] - b0, 10);
    chk("fs_events", evq.size(), 0);
    chk("fs_busy_end", busy_w[0], 0);
    run_frame(0, 'hC3, -1, 1, 1, 0);

    // Overrun with consumer stalled, back-to-back frames.
    evq.delete();
    rdy_r[0] = 1'b0;
    send_frame(0, 'h11, -1, 1, 1, t0a);
    send_frame(0, 'h22, -1, 1, 1, t0b);
    tick_n(4);
    chk("ovr_events", evq.size(), 2);
    if (evq.size() >= 2) begin
      e = evq.pop_front();
      chk("ovr_w_kind", e.kind, 0);
      chk("ovr_w_data", e.data, 'h11);
      chk("ovr_w_cycle", e.cyc, t0a + 3 + OS * 9 + OS / 2 + 2);
      e = evq.pop_front();
      chk("ovr_kind", e.kind, 2);
      chk("ovr_cycle", e.cyc, t0b + 3 + OS * 9 + OS / 2 + 2);
    end
    chk("ovr_dout", dout_w[0], 'h11);
    chk("ovr_valid", val_w[0], 1);
    chk("ovr_rts", rts_w[0], 1);
    rdy_r[0] = 1'b1;
    chk("ovr_valid_hold", val_w[0], 1);
    tick_n(1);
    chk("ovr_valid_drop", val_w[0], 0);
    chk("ovr_rts_drop", rts_w[0], 0);
    tick_n(2);
    chk("ovr_no_more", evq.size(), 0);

    // 7N2: good word, second stop low, reset mid-data, then intact frame.
    run_frame(2, 'h7F, -1, 1, 1, 0);
    run_frame(2, 'h15, -1, 1, 0, 40);
    evq.delete();
    drive(2, 1'b0, OS);
    drive(2, 1'b1, OS);
    drive(2, 1'b0, OS);
    reset   = 1'b1;
    rx_r[2] = 1'b1;
    tick_n(2);
    chk("mid_rst_dout", dout_w[2], 0);
    chk("mid_rst_valid", val_w[2], 0);
    chk("mid_rst_perr", perr_w[2], 0);
    chk("mid_rst_fe", fe_w[2], 0);
    chk("mid_rst_ovr", ov_w[2], 0);
    chk("mid_rst_rts", rts_w[2], 0);
    chk("mid_rst_busy", busy_w[2], 0);
    reset = 1'b0;
    tick_n(6);
    chk("mid_rst_events", evq.size(), 0);
    run_frame(2, 'h55, -1, 1, 1, 0);

    // Random frames on every configuration.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 10; k++) begin
        d  = int'($urandom) & ((1 << nb_of(i)) - 1);
        p  = (par_of(i) != 0) ? int'($urandom_range(0, 1)) : -1;
        s1 = 1;
        s2 = 1;
        if ($urandom_range(0, 5) == 0) begin
          if (ns_of(i) == 2 && $urandom_range(0, 1) == 1) s2 = 0;
          else begin
            s1 = 0;
            s2 = 0;
          end
        end
        run_frame(i, d, p, s1, s2, int'($urandom_range(20, 60)));
        tick_n(int'($urandom_range(0, 6)));
      end
    end

    tick_n(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
